tap_tempo_m: RTL and testbench

TAP_TEMPO_M -- requirements
Module: tap_tempo_m

---
 rtl/tap_tempo_m.sv | 209 ++++++++++++++++++++
 tb/tb_tap_tempo_m.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tap_tempo_m.sv
// tap_tempo_m: tap-tempo meter. A debounced push-button is timed between
// rising edges, and the interval is converted to beats per minute with a
// 32-cycle restoring divider (bpm = floor(60*CLK_HZ / interval)).
// Build option: define TAP_TEMPO_AVG_EN to divide by the mean of the last
// four accepted intervals instead of the single latest interval.
// Output protocol: bpm_valid is a one-cycle strobe with no ready/back-pressure;
// bpm is stable from that cycle until the next strobe, and holds across timeouts.
module tap_tempo_m #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned BPM_MIN         = 30,
  parameter int unsigned BPM_MAX         = 250,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tap,
  output logic [7:0] bpm,
  output logic       bpm_valid,
  output logic       locked,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam logic [31:0] K       = 32'(64'(CLK_HZ) * 64'd60);
  localparam logic [31:0] MIN_INT = K / BPM_MAX;
  localparam logic [31:0] MAX_INT = K / BPM_MIN;
  localparam int          DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DIV   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sync1, r_sync2;
  logic              r_db, r_db_prev;
  logic [DB_W-1:0]   r_db_cnt;
  logic [31:0]       r_cnt;
  logic [31:0]       r_div;
  logic [31:0]       r_quo;
  logic [31:0]       r_rem;
  logic [4:0]        r_iter;
  logic              w_tap_evt;
  logic              w_timeout;
  logic              w_accept;
  logic              w_start_div;
  logic              w_div_last;
  logic [31:0]       w_divisor;
  logic [32:0]       w_rem_sh;
  logic              w_fits;
  logic [31:0]       w_diff;
  logic [31:0]       w_rem_nxt;
  logic [31:0]       w_quo_nxt;

  // Two-flop synchronizer for the raw asynchronous button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= tap;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncer: flip the level only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db      <= 1'b0;
      r_db_prev <= 1'b0;
      r_db_cnt  <= '0;
    end else begin
      r_db_prev <= r_db;
      if (r_sync2 != r_db) begin
        if (r_db_cnt == DB_LAST) begin
          r_db     <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_tap_evt  = r_db & ~r_db_prev;
  // Timeout outranks any tap arriving in the same cycle.
  assign w_timeout  = (r_state == S_COUNT) && (r_cnt > MAX_INT);
  assign w_accept   = (r_state == S_COUNT) && w_tap_evt && !w_timeout && (r_cnt >= MIN_INT);
  assign w_div_last = (r_state == S_DIV) && (r_iter == 5'd31);

`ifdef TAP_TEMPO_AVG_EN
  // The three previous accepted intervals; the incoming interval is the fourth entry.
  logic [31:0] r_hist [0:2];
  logic [1:0]  r_hist_cnt;
  logic [33:0] w_sum;

  assign w_sum       = {2'b00, r_hist[0]} + {2'b00, r_hist[1]} +
                       {2'b00, r_hist[2]} + {2'b00, r_cnt};
  assign w_divisor   = w_sum[33:2];
  assign w_start_div = w_accept && (r_hist_cnt == 2'd3);

  // History shift register, emptied on timeout so a fresh sequence refills it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) r_hist[i] <= '0;
      r_hist_cnt <= 2'd0;
    end else if (w_timeout) begin
      r_hist_cnt <= 2'd0;
    end else if (w_accept) begin
      r_hist[2] <= r_hist[1];
      r_hist[1] <= r_hist[0];
      r_hist[0] <= r_cnt;
      if (r_hist_cnt != 2'd3) r_hist_cnt <= r_hist_cnt + 2'd1;
    end
  end
`else
  assign w_divisor   = r_cnt;
  assign w_start_div = w_accept;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_tap_evt) w_state_nxt = S_COUNT;
      S_COUNT: begin
        if (w_timeout)        w_state_nxt = S_IDLE;
        else if (w_start_div) w_state_nxt = S_DIV;
      end
      S_DIV:   if (w_div_last) w_state_nxt = S_COUNT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Interval counter: saturating, keeps running through DIV so the next interval is timed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_COUNT: begin
          if (w_timeout || w_accept) r_cnt <= '0;
          else if (r_cnt != '1)      r_cnt <= r_cnt + 32'd1;
        end
        S_DIV:   if (r_cnt != '1) r_cnt <= r_cnt + 32'd1;
        default: r_cnt <= '0;
      endcase
    end
  end

  // One restoring-divide step: remainder never exceeds 32 bits because it stays below the divisor.
  assign w_rem_sh  = {r_rem, r_quo[31]};
  assign w_fits    = (w_rem_sh >= {1'b0, r_div});
  assign w_diff    = w_rem_sh[31:0] - r_div;
  assign w_rem_nxt = w_fits ? w_diff : w_rem_sh[31:0];
  assign w_quo_nxt = {r_quo[30:0], w_fits};

  // Divider registers: loaded when an interval is accepted, stepped once per DIV cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_iter <= '0;
    end else if (w_start_div) begin
      r_div  <= w_divisor;
      r_quo  <= K;
      r_rem  <= '0;
      r_iter <= '0;
    end else if (r_state == S_DIV) begin
      r_quo  <= w_quo_nxt;
      r_rem  <= w_rem_nxt;
      r_iter <= r_iter + 5'd1;
    end
  end

  // Result registers: bpm and lock update on the final divide step; timeout only drops lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bpm       <= '0;
      bpm_valid <= 1'b0;
      locked    <= 1'b0;
    end else begin
      bpm_valid <= 1'b0;
      if (w_div_last) begin
        bpm       <= w_quo_nxt[7:0];
        bpm_valid <= 1'b1;
        locked    <= 1'b1;
      end else if (w_timeout) begin
        locked <= 1'b0;
      end
    end
  end

  assign busy      = (r_state == S_DIV);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tap_tempo_m.sv
// tb_tap_tempo_m: directed bench for tap_tempo_m with a bpm_valid scoreboard.
// Small parameters: K=60000, MIN_INT=240, MAX_INT=2000, 4-cycle debounce.
// A press driven just after edge n gives a debounced edge after edge n+6,
// the tap event is registered at edge n+7, and bpm_valid shows after edge n+39.
module tb_tap_tempo_m;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DIV   = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tap;
  logic [7:0] bpm;
  logic       bpm_valid;
  logic       locked;
  logic       busy;
  logic [1:0] dbg_state;

  int cyc     = 0;
  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // {expected cycle, expected bpm}
  logic [39:0] exp_q[$];

  tap_tempo_m #(
    .CLK_HZ(1000),
    .BPM_MIN(30),
    .BPM_MAX(250),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tap(tap),
    .bpm(bpm),
    .bpm_valid(bpm_valid),
    .locked(locked),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Driver: press the button just after the edge where cyc reaches c; release 20 cycles later.
  task automatic press_at(input int c, output int t);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
    tap = 1'b1;
    t = cyc;
    fork
      begin
        repeat (20) @(posedge clk);
        #1 tap = 1'b0;
      end
    join_none
  endtask

  task automatic sample(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expect_bpm(input int t, input logic [7:0] v);
    exp_q.push_back({32'(t + 39), v});
  endtask

  // Scoreboard: every bpm_valid pulse must match the head of the expected queue.
  always @(negedge clk) begin
    logic [39:0] e;
    if (bpm_valid) begin
      check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("bpm_value", 32'(bpm), 32'(e[7:0]));
        check("valid_cycle", 32'(cyc), e[39:8]);
      end
    end
  end

  initial begin
    int t0, t1, t2, t3, t4, t5, t6, t7, t8, t9;
    rst_n = 1'b0;
    tap   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_bpm", 32'(bpm), 32'd0);
    check("rst_valid", 32'(bpm_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Three-cycle glitches must never reach the debounced level
    for (int g = 0; g < 3; g++) begin
      tap = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      tap = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
    end
    @(negedge clk);
    check("glitch_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Held press: first tap from IDLE starts timing, no result
    press_at(cyc + 5, t0);
    sample(t0 + 6);
    check("evt_before", 32'(dbg_state), 32'(ST_IDLE));
    sample(t0 + 7);
    check("evt_count", 32'(dbg_state), 32'(ST_COUNT));

`ifdef TAP_TEMPO_AVG_EN
    // Intervals 500, 500, 600, 400: only the fourth produces a result
    press_at(t0 + 500, t1);
    sample(t1 + 8);
    check("avg1_busy", 32'(busy), 32'd0);
    check("avg1_state", 32'(dbg_state), 32'(ST_COUNT));
    press_at(t1 + 500, t2);
    press_at(t2 + 600, t3);
    sample(t3 + 8);
    check("avg3_busy", 32'(busy), 32'd0);
    press_at(t3 + 400, t4);
    expect_bpm(t4, 8'd120);
    sample(t4 + 7);
    check("avg4_busy", 32'(busy), 32'd1);
    sample(t4 + 38);
    check("avg4_locked_pre", 32'(locked), 32'd0);
    sample(t4 + 39);
    check("avg4_locked", 32'(locked), 32'd1);
    check("avg4_busy_done", 32'(busy), 32'd0);
    check("avg4_state", 32'(dbg_state), 32'(ST_COUNT));
`else
    // Three taps 500 apart: two results of 120
    press_at(t0 + 500, t1);
    expect_bpm(t1, 8'd120);
    sample(t1 + 6);
    check("busy_pre", 32'(busy), 32'd0);
    sample(t1 + 7);
    check("busy_first", 32'(busy), 32'd1);
    check("state_div", 32'(dbg_state), 32'(ST_DIV));
    sample(t1 + 38);
    check("busy_last", 32'(busy), 32'd1);
    check("locked_pre", 32'(locked), 32'd0);
    sample(t1 + 39);
    check("busy_done", 32'(busy), 32'd0);
    check("locked_set", 32'(locked), 32'd1);
    check("state_back", 32'(dbg_state), 32'(ST_COUNT));
    press_at(t1 + 500, t2);
    expect_bpm(t2, 8'd120);

    // Timeout after 2001 idle cycles drops lock, keeps bpm
    sample(t2 + 2008);
    check("to_locked_pre", 32'(locked), 32'd1);
    check("to_state_pre", 32'(dbg_state), 32'(ST_COUNT));
    sample(t2 + 2009);
    check("to_locked", 32'(locked), 32'd0);
    check("to_state", 32'(dbg_state), 32'(ST_IDLE));
    check("to_bpm_hold", 32'(bpm), 32'd120);
    press_at(t2 + 2100, t3);
    sample(t3 + 60);
    check("to_next_state", 32'(dbg_state), 32'(ST_COUNT));
    check("to_next_locked", 32'(locked), 32'd0);

    // Intervals 500, 100 (ignored), then 400 from the accepted tap
    press_at(t3 + 500, t4);
    expect_bpm(t4, 8'd120);
    press_at(t4 + 100, t5);
    sample(t5 + 8);
    check("short_busy", 32'(busy), 32'd0);
    check("short_state", 32'(dbg_state), 32'(ST_COUNT));
    press_at(t4 + 400, t6);
    expect_bpm(t6, 8'd150);
    sample(t6 + 39);
    check("bpm_150", 32'(bpm), 32'd150);

    // Reset in the middle of a divide
    press_at(t6 + 500, t7);
    sample(t7 + 20);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bpm", 32'(bpm), 32'd0);
    check("mid_rst_valid", 32'(bpm_valid), 32'd0);
    check("mid_rst_locked", 32'(locked), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("post_rst_bpm", 32'(bpm), 32'd0);

    // First tap after reset behaves as IDLE, then a normal measurement
    press_at(cyc + 5, t8);
    sample(t8 + 7);
    check("post_rst_count", 32'(dbg_state), 32'(ST_COUNT));
    press_at(t8 + 500, t9);
    expect_bpm(t9, 8'd120);
    sample(t9 + 39);
    check("post_rst_locked", 32'(locked), 32'd1);
`endif

    repeat (5) @(negedge clk);
    check("missing_valid", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
